// File: rtl/axis_packet_framer_if.sv
// AXI4-Stream bundle shared by the framer's input and output sides.
// The master drives data, strobes, valid and last; the slave drives ready.
interface axis_packet_framer_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0]   TDATA;
  logic [DW/8-1:0] TSTRB;
  logic            TVALID;
  logic            TREADY;
  logic            TLAST;

  modport master (output TDATA, TSTRB, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TSTRB, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/axis_packet_framer.sv
// Buffers an unframed AXI4-Stream and re-emits it as PKT_LEN-word packets with TLAST.
// A partial packet left behind by a stalled source is flushed after TIMEOUT idle cycles.
module axis_packet_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_LEN            = 8,
  parameter int FIFO_DEPTH         = 16,
  parameter int TIMEOUT            = 32
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESET,
  axis_packet_framer_if.slave  s_axis,
  axis_packet_framer_if.master m_axis,
  output logic [15:0]          pkt_count,
  output logic [0:0]           dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(PKT_LEN);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [15:0] IDLE_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [C_AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat_cnt;
  logic [15:0]   idle_cnt;
  logic [0:0]    state;

  logic s_ready;
  logic m_valid;
  logic m_last;
  logic wr;
  logic rd;
  logic idle_qual;
  logic unused_inputs;

  // Handshake: a word moves on any cycle where VALID and READY are both high;
  // once VALID is raised the master holds TDATA/TLAST/VALID until READY is seen.
  assign wr = s_axis.TVALID & s_ready;
  assign rd = m_valid & m_axis.TREADY;

  always_comb begin
    s_ready = (state == RUN) && (count != CW'(FIFO_DEPTH)) && !AXIS_ARESET;
    if (state == RUN) begin
      // Store-and-forward: a packet only starts once it is fully buffered.
      m_valid = (beat_cnt != '0) || (count >= CW'(PKT_LEN));
      m_last  = m_valid && (beat_cnt == BW'(PKT_LEN - 1));
    end else begin
      m_valid = (count != '0);
      m_last  = m_valid && (count == CW'(1));
    end
  end

  assign idle_qual = (state == RUN) && !wr && (beat_cnt == '0) && (count != '0) &&
                     (count < CW'(PKT_LEN)) && (TIMEOUT != 0);

  assign s_axis.TREADY = s_ready;
  assign m_axis.TDATA  = mem[rd_ptr];
  assign m_axis.TSTRB  = '1;
  assign m_axis.TVALID = m_valid;
  assign m_axis.TLAST  = m_last;
  assign dbg_state     = state;

  assign unused_inputs = &{1'b0, s_axis.TSTRB, s_axis.TLAST};

  always_ff @(posedge AXIS_ACLK) begin
    if (wr) mem[wr_ptr] <= s_axis.TDATA;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      pkt_count <= '0;
      state     <= RUN;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;

      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (rd) beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
      if (rd && m_last) pkt_count <= pkt_count + 1'b1;

      if (idle_qual) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_cnt <= '0;
          state    <= FLUSH;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      // The flushed TLAST drains the FIFO completely, so RUN resumes from empty.
      if (state == FLUSH && rd && m_last) state <= RUN;
    end
  end
endmodule

// File: tb/tb_axis_packet_framer.sv
// Bench for axis_packet_framer: directed scenarios plus random data/backpressure,
// checked cycle by cycle against a packet-level model of the framing rules.
module tb_axis_packet_framer;
  localparam int DW         = 32;
  localparam int PKT_LEN    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 32;
  localparam int W          = DW + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pkt_count;
  logic [0:0]  dbg_state;

  axis_packet_framer_if #(.DW(DW)) s_if ();
  axis_packet_framer_if #(.DW(DW)) m_if ();

  assign s_if.TSTRB = '1;
  assign s_if.TLAST = 1'b0;

  axis_packet_framer #(
    .C_AXIS_TDATA_WIDTH(DW),
    .PKT_LEN(PKT_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .pkt_count(pkt_count),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words waiting to complete a packet, complete packets
  // awaiting output ({last, data}), and the packet-level idle/flush rules.
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] pend_q[$];
  bit            flushing = 1'b0;
  int            idle_run = 0;
  int            model_pkts = 0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_word;
  logic [W-1:0]  head;
  bit            exp_v, exp_rdy, acc, rdx, qual;

  function automatic void frame_pending();
    for (int i = 0; i < pend_q.size(); i++)
      exp_q.push_back({(i == pend_q.size() - 1), pend_q[i]});
    pend_q.delete();
  endfunction

  // Scoreboard: evaluated mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (s_if.TREADY !== 1'b0) begin
        $display("FAIL reset_tready: got %b want 0", s_if.TREADY);
        errors++;
      end
      exp_q.delete();
      pend_q.delete();
      flushing   = 1'b0;
      idle_run   = 0;
      model_pkts = 0;
      prev_stall = 1'b0;
    end else begin
      exp_v   = (exp_q.size() != 0);
      exp_rdy = !flushing && (exp_q.size() + pend_q.size() < FIFO_DEPTH);
      checks++;
      if (m_if.TVALID !== exp_v) begin
        $display("FAIL m_tvalid: got %b want %b", m_if.TVALID, exp_v);
        errors++;
      end
      checks++;
      if (s_if.TREADY !== exp_rdy) begin
        $display("FAIL s_tready: got %b want %b", s_if.TREADY, exp_rdy);
        errors++;
      end
      checks++;
      if (pkt_count !== 16'(model_pkts)) begin
        $display("FAIL pkt_count: got %0d want %0d", pkt_count, 16'(model_pkts));
        errors++;
      end
      if (prev_stall) begin
        checks++;
        if (m_if.TVALID !== 1'b1 || {m_if.TLAST, m_if.TDATA} !== prev_word) begin
          $display("FAIL hold: got v=%b %h want v=1 %h", m_if.TVALID, {m_if.TLAST, m_if.TDATA}, prev_word);
          errors++;
        end
      end
      if (exp_v && m_if.TVALID === 1'b1) begin
        head = exp_q[0];
        checks++;
        if ({m_if.TLAST, m_if.TDATA} !== head) begin
          $display("FAIL out_word: got last=%b data=%h want last=%b data=%h",
                   m_if.TLAST, m_if.TDATA, head[W-1], head[DW-1:0]);
          errors++;
        end
      end

      acc  = (s_if.TVALID === 1'b1) && (s_if.TREADY === 1'b1);
      rdx  = (m_if.TVALID === 1'b1) && (m_if.TREADY === 1'b1);
      qual = !acc && !flushing && !exp_v && (pend_q.size() != 0);

      if (rdx && exp_v) begin
        head = exp_q.pop_front();
        if (head[W-1]) begin
          model_pkts++;
          flushing = 1'b0;
        end
      end

      if (acc) begin
        idle_run = 0;
        pend_q.push_back(s_if.TDATA);
        if (pend_q.size() == PKT_LEN) frame_pending();
      end else if (qual) begin
        idle_run++;
        if (idle_run == TIMEOUT) begin
          frame_pending();
          flushing = 1'b1;
          idle_run = 0;
        end
      end else begin
        idle_run = 0;
      end

      prev_stall = (m_if.TVALID === 1'b1) && (m_if.TREADY !== 1'b1);
      prev_word  = {m_if.TLAST, m_if.TDATA};
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst         = 1'b1;
    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    m_if.TREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int n = 0;
    s_if.TDATA  = d;
    s_if.TVALID = 1'b1;
    @(negedge clk);
    while (s_if.TREADY !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_if.TREADY !== 1'b1) begin
      $display("FAIL push_timeout: got tready=%b want 1 within 2000 cycles", s_if.TREADY);
      errors++;
    end
    @(posedge clk);
    #1 s_if.TVALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0 || flushing) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      $display("FAIL %s_drain: got %0d words outstanding want 0", tag, exp_q.size() + pend_q.size());
      errors++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_pkts(input string tag, input int want);
    checks++;
    if (pkt_count !== 16'(want)) begin
      $display("FAIL %s_pkt_count: got %0d want %0d", tag, pkt_count, want);
      errors++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    checks++;
    if (m_if.TVALID !== 1'b0 || m_if.TLAST !== 1'b0) begin
      $display("FAIL reset_out: got v=%b l=%b want 0 0", m_if.TVALID, m_if.TLAST);
      errors++;
    end
    check_pkts("reset", 0);
    checks++;
    if (dbg_state !== 1'b0) begin
      $display("FAIL reset_state: got %b want 0", dbg_state);
      errors++;
    end
    m_if.TREADY = 1'b1;
    idle_cycles(40);
    checks++;
    if (m_if.TVALID !== 1'b0 || dbg_state !== 1'b0) begin
      $display("FAIL empty_idle: got v=%b state=%b want 0 0", m_if.TVALID, dbg_state);
      errors++;
    end
  endtask

  task automatic test_full_packet();
    apply_reset();
    m_if.TREADY = 1'b1;
    for (int i = 1; i <= PKT_LEN; i++) begin
      push_word(DW'(i));
      if (i == PKT_LEN - 1) begin
        checks++;
        if (m_if.TVALID !== 1'b0) begin
          $display("FAIL gate_before_full: got %b want 0", m_if.TVALID);
          errors++;
        end
      end
    end
    checks++;
    if (m_if.TVALID !== 1'b1 || m_if.TDATA !== DW'(1)) begin
      $display("FAIL first_latency: got v=%b d=%h want v=1 d=1", m_if.TVALID, m_if.TDATA);
      errors++;
    end
    wait_drain("full");
    check_pkts("full", 1);
  endtask

  task automatic test_flush();
    int n = 0;
    apply_reset();
    m_if.TREADY = 1'b0;
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    while (m_if.TVALID !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT + 1) begin
      $display("FAIL flush_delay: got %0d cycles want %0d", n, TIMEOUT + 1);
      errors++;
    end
    repeat (3) begin
      checks++;
      if (s_if.TREADY !== 1'b0 || dbg_state !== 1'b1) begin
        $display("FAIL flush_state: got tready=%b state=%b want 0 1", s_if.TREADY, dbg_state);
        errors++;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 m_if.TREADY = 1'b1;
    wait_drain("flush");
    check_pkts("flush", 1);
  endtask

  task automatic test_fill();
    apply_reset();
    m_if.TREADY = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) push_word(32'h100 + DW'(i));
    s_if.TDATA  = 32'h1FF;
    s_if.TVALID = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_if.TREADY !== 1'b0) begin
        $display("FAIL full_tready: got %b want 0", s_if.TREADY);
        errors++;
      end
    end
    @(posedge clk);
    #1 m_if.TREADY = 1'b1;
    push_word(32'h1FF);
    wait_drain("fill");
    check_pkts("fill", 3);
  endtask

  task automatic test_gap();
    apply_reset();
    m_if.TREADY = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h200 + DW'(i));
    idle_cycles(TIMEOUT - 1);
    for (int i = 4; i < PKT_LEN; i++) push_word(32'h200 + DW'(i));
    checks++;
    if (m_if.TVALID !== 1'b1 || dbg_state !== 1'b0) begin
      $display("FAIL gap_no_flush: got v=%b state=%b want 1 0", m_if.TVALID, dbg_state);
      errors++;
    end
    wait_drain("gap");
    check_pkts("gap", 1);
  endtask

  task automatic test_backpressure();
    apply_reset();
    fork
      begin
        for (int i = 0; i < 10 * PKT_LEN; i++) begin
          push_word($urandom);
          idle_cycles($urandom_range(0, 3));
        end
      end
      begin
        repeat (600) begin
          m_if.TREADY = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    m_if.TREADY = 1'b1;
    wait_drain("bp");
    check_pkts("bp", 10);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_if.TREADY = 1'b0;
    for (int i = 0; i < PKT_LEN; i++) push_word(32'h300 + DW'(i));
    m_if.TREADY = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    m_if.TREADY = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (m_if.TVALID !== 1'b0) begin
      $display("FAIL mid_reset_valid: got %b want 0", m_if.TVALID);
      errors++;
    end
    check_pkts("mid_reset", 0);
    m_if.TREADY = 1'b1;
    for (int i = 0; i < PKT_LEN; i++) push_word(32'h400 + DW'(i));
    wait_drain("mid_reset");
    check_pkts("after_reset", 1);
  endtask

  initial begin
    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    m_if.TREADY = 1'b0;
    test_reset();
    test_full_packet();
    test_flush();
    test_fill();
    test_gap();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
